lutram_march_tester: RTL and testbench
======================================

# lutram_march_tester

Parametrised self-checking tester for one distributed-RAM (LUTRAM) instance of any depth and width. It first verifies the instance's INIT contents, then runs a four-phase march with address-dependent data, and reports pass/fail, error count and first failing address. It sits in the primitive-test top between the BUFG-driven clock and the instantiated RAM32X1S/RAM64M-style primitive, and drives the status LEDs.

## Interface

Parameters:
- DEPTH, 64: words in the RAM under test; power of two, 2..256.
- WIDTH, 1: bits per word, 1..8.
- AW, $clog2(DEPTH): address width.
- INIT, 0 (DEPTH*WIDTH bits): expected power-up contents; word a is INIT[a*WIDTH +: WIDTH].
- SEED, 8'hA5: pattern seed; the low WIDTH bits are used.

Ports:
- clk_i, input, 1: single clock, already buffered; all logic on the rising edge.
- rst_i, input, 1: synchronous, active-high reset.
- start_i, input, 1: level; sampled in IDLE or DONE.
- ram_we_o, output, 1: write enable to the RAM under test.
- ram_addr_o, output, AW: shared read/write address.
- ram_d_o, output, WIDTH: write data.
- ram_q_i, input, WIDTH: asynchronous read data, valid within the same cycle as ram_addr_o.
- busy_o, output, 1: high from the first test cycle through the drain cycle.
- done_o, output, 1: high in DONE.
- pass_o, output, 1: high in DONE when err_cnt_o == 0.
- err_cnt_o, output, 16: mismatching words; saturates at 16'hFFFF.
- fail_addr_o, output, AW: address of the first mismatch.
- fail_phase_o, output, 2: phase of the first mismatch (0 INIT, 2 RW, 3 RD).
- q_o, output, 8: LED byte {pass_o, done_o, busy_o, err_cnt_o!=0, 1'b0, phase[1:0], busy_o & addr[0]}.

## Operation

- Pattern: P(a) = SEED[WIDTH-1:0] XOR a[WIDTH-1:0], where a is zero-extended if AW < WIDTH.
- States: IDLE → INIT (phase 0) → WR (1) → RW (2) → RD (3) → FIN → DONE. DONE → INIT when start_i is sampled high.
- INIT: addresses 0..DEPTH-1 ascending, one per cycle, we=0; compare ram_q_i against the INIT word.
- WR: addresses 0..DEPTH-1 ascending, one per cycle; we=1, d=P(a).
- RW: addresses ascending, two cycles per address. The read cycle (we=0) compares against P(a). The write cycle (we=1) writes ~P(a).
- RD: addresses DEPTH-1..0 descending, one per cycle, we=0; compare against ~P(a).
- Compare is pipelined one stage: at the edge after a read cycle, {expected, ram_q_i, addr, phase} are registered. The mismatch is evaluated in the next cycle. FIN exists to drain this stage.
- On each mismatch, err_cnt_o increments by 1 and saturates. If err_cnt_o was 0, fail_addr_o and fail_phase_o latch the failing address and phase.
- A restart from DONE clears err_cnt_o, fail_addr_o, fail_phase_o, pass_o and done_o at the start edge.
- start_i is ignored while busy_o is high.
- Reads always follow the write of the same address by at least one full cycle, so the RAM may use a rising- or falling-edge write clock (IS_WCLK_INVERTED either value) without changing results.

## Timing

- Reset values:
  - state IDLE, ram_we_o=0, ram_addr_o=0, ram_d_o=0.
  - busy_o, done_o, pass_o = 0.
  - err_cnt_o=0, fail_addr_o=0, fail_phase_o=0, q_o=0.
- Reset mid-test returns to IDLE on the next edge with all outputs at reset values. ram_we_o is low from that edge onward.
- Edge E0 samples start_i=1. From E0, busy_o=1 and state is INIT with ram_addr_o=0.
- Phase lengths in cycles: INIT DEPTH, WR DEPTH, RW 2*DEPTH, RD DEPTH.
- FIN is 1 cycle. done_o and pass_o assert at edge E0+5*DEPTH+1, and busy_o falls at the same edge.
- ram_we_o, ram_addr_o and ram_d_o are registered outputs, with no combinational path from ram_q_i.
- Address wrap: the final increment in WR and RW, and the final decrement in RD, must not generate an extra access.
- Total accesses per run: exactly 5*DEPTH. ram_we_o is high for exactly 2*DEPTH cycles.

## Test plan

- Behavioural RAM model with DEPTH=32, WIDTH=1, INIT=32'hDEADBEEF, SEED=1; start pulse → done_o at E0+161, pass_o=1, err_cnt_o=0, ram_we_o high for 64 cycles.
- Same config, model preloaded with INIT=32'hDEADBEEE (bit 0 flipped) → err_cnt_o=1, fail_addr_o=0, fail_phase_o=0, pass_o=0.
- DEPTH=64, WIDTH=4, model with address 37 bit 2 stuck-at-1 → first failure at fail_phase_o=2 (or 3 if P(37) bit 2 is 1), fail_addr_o=37, pass_o=0.
- DEPTH=256, WIDTH=1, model that ignores every write (read-only) → err_cnt_o=256 (mismatches wherever P or ~P differ from INIT), fail_phase_o=2, busy_o low at E0+1281.
- Assert rst_i at cycle 100 of a DEPTH=64 run → next cycle all outputs 0 and state IDLE. A new start then completes normally with pass_o=1.
- Model with a falling-edge write (inverted WCLK), DEPTH=64, WIDTH=2 → pass_o=1. Then restart from DONE: err_cnt_o and done_o clear at the start edge, and the second run passes identically.

Source files
------------

// File: rtl/lutram_march_tester.sv
// +--------------------------------------------------------------------------+
// | lutram_march_tester: INIT check plus four-phase march for one LUTRAM     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module lutram_march_tester #(
  parameter int                     DEPTH = 64,
  parameter int                     WIDTH = 1,
  parameter int                     AW    = $clog2(DEPTH),
  parameter logic [DEPTH*WIDTH-1:0] INIT  = '0,
  parameter logic [7:0]             SEED  = 8'hA5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  output logic             ram_we_o,
  output logic [AW-1:0]    ram_addr_o,
  output logic [WIDTH-1:0] ram_d_o,
  input  logic [WIDTH-1:0] ram_q_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             pass_o,
  output logic [15:0]      err_cnt_o,
  output logic [AW-1:0]    fail_addr_o,
  output logic [1:0]       fail_phase_o,
  output logic [7:0]       q_o
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_INIT = 3'd1,
    S_WR   = 3'd2,
    S_RW   = 3'd3,
    S_RD   = 3'd4,
    S_FIN  = 3'd5,
    S_DONE = 3'd6
  } state_t;

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  state_t           state, state_nx;
  logic [AW-1:0]    addr, addr_nx;
  logic             we, we_nx;
  logic [WIDTH-1:0] wdata, wdata_nx;

  logic             rd_cycle;
  logic [WIDTH-1:0] rd_exp;
  logic [1:0]       phase;
  logic             start_go;

  logic             cmp_vld;
  logic [WIDTH-1:0] cmp_exp;
  logic [WIDTH-1:0] cmp_q;
  logic [AW-1:0]    cmp_addr;
  logic [1:0]       cmp_phase;
  logic             mismatch;

  logic [15:0]      err_cnt;
  logic [AW-1:0]    fail_addr;
  logic [1:0]       fail_phase;
  logic             pass;

  // Address is zero-extended before the XOR so narrow RAMs still get WIDTH bits.
  function automatic logic [WIDTH-1:0] pat(input logic [AW-1:0] a);
    logic [AW+WIDTH-1:0] ext;
    ext = {{WIDTH{1'b0}}, a};
    return SEED[WIDTH-1:0] ^ ext[WIDTH-1:0];
  endfunction

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= S_IDLE;
      addr  <= '0;
      we    <= 1'b0;
      wdata <= '0;
    end else begin
      state <= state_nx;
      addr  <= addr_nx;
      we    <= we_nx;
      wdata <= wdata_nx;
    end
  end

  // The final step of each sweep parks the address instead of wrapping.
  always_comb begin
    state_nx = state;
    addr_nx  = addr;
    we_nx    = 1'b0;
    wdata_nx = '0;
    case (state)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          state_nx = S_INIT;
          addr_nx  = '0;
        end
      end
      S_INIT: begin
        if (addr == LAST_ADDR) begin
          state_nx = S_WR;
          addr_nx  = '0;
          we_nx    = 1'b1;
          wdata_nx = pat('0);
        end else begin
          addr_nx = addr + 1'b1;
        end
      end
      S_WR: begin
        if (addr == LAST_ADDR) begin
          state_nx = S_RW;
          addr_nx  = '0;
        end else begin
          addr_nx  = addr + 1'b1;
          we_nx    = 1'b1;
          wdata_nx = pat(addr + 1'b1);
        end
      end
      S_RW: begin
        if (!we) begin
          we_nx    = 1'b1;
          wdata_nx = ~pat(addr);
        end else if (addr == LAST_ADDR) begin
          state_nx = S_RD;
        end else begin
          addr_nx = addr + 1'b1;
        end
      end
      S_RD: begin
        if (addr == '0) begin
          state_nx = S_FIN;
        end else begin
          addr_nx = addr - 1'b1;
        end
      end
      S_FIN:   state_nx = S_DONE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    rd_cycle = 1'b0;
    rd_exp   = '0;
    phase    = 2'd0;
    case (state)
      S_INIT: begin
        rd_cycle = 1'b1;
        rd_exp   = INIT[int'(addr)*WIDTH +: WIDTH];
      end
      S_WR: phase = 2'd1;
      S_RW: begin
        phase    = 2'd2;
        rd_cycle = !we;
        rd_exp   = pat(addr);
      end
      S_RD: begin
        phase    = 2'd3;
        rd_cycle = 1'b1;
        rd_exp   = ~pat(addr);
      end
      default: ;
    endcase
  end

  assign start_go = ((state == S_IDLE) || (state == S_DONE)) && start_i;
  assign mismatch = cmp_vld && (cmp_exp != cmp_q);

  // Read data is captured at the edge ending the read and judged one cycle later.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cmp_vld    <= 1'b0;
      cmp_exp    <= '0;
      cmp_q      <= '0;
      cmp_addr   <= '0;
      cmp_phase  <= 2'd0;
      err_cnt    <= 16'd0;
      fail_addr  <= '0;
      fail_phase <= 2'd0;
      pass       <= 1'b0;
    end else begin
      cmp_vld   <= rd_cycle;
      cmp_exp   <= rd_exp;
      cmp_q     <= ram_q_i;
      cmp_addr  <= addr;
      cmp_phase <= phase;
      if (start_go) begin
        err_cnt    <= 16'd0;
        fail_addr  <= '0;
        fail_phase <= 2'd0;
        pass       <= 1'b0;
      end else begin
        if (mismatch) begin
          if (err_cnt == 16'd0) begin
            fail_addr  <= cmp_addr;
            fail_phase <= cmp_phase;
          end
          if (err_cnt != 16'hFFFF) begin
            err_cnt <= err_cnt + 16'd1;
          end
        end
        if (state == S_FIN) begin
          pass <= (err_cnt == 16'd0) && !mismatch;
        end
      end
    end
  end

  assign ram_we_o     = we;
  assign ram_addr_o   = addr;
  assign ram_d_o      = wdata;
  assign busy_o       = (state != S_IDLE) && (state != S_DONE);
  assign done_o       = (state == S_DONE);
  assign pass_o       = pass;
  assign err_cnt_o    = err_cnt;
  assign fail_addr_o  = fail_addr;
  assign fail_phase_o = fail_phase;
  assign q_o          = {pass, done_o, busy_o, (err_cnt != 16'd0), 1'b0, phase, busy_o & addr[0]};

endmodule

`default_nettype wire

// File: tb/tb_lutram_march_tester.sv
// +--------------------------------------------------------------------------+
// | tb_lutram_march_tester: five tester instances against behavioural RAMs   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_lutram_march_tester;

  localparam int NI = 5;
  localparam logic [31:0]  INIT_A = 32'hDEADBEEF;
  localparam logic [31:0]  LOAD_B = 32'hDEADBEEE;
  localparam logic [255:0] INIT_C = 256'd1 << 150;
  localparam logic [127:0] INIT_E = 128'h0123456789ABCDEFFEDCBA9876543210;

  logic clk = 1'b0;
  logic rst   [NI];
  logic start [NI];
  logic load  [NI];

  logic        we_w   [NI];
  logic        busy_w [NI];
  logic        done_w [NI];
  logic        pass_w [NI];
  logic [15:0] err_w  [NI];
  logic [1:0]  fp_w   [NI];
  logic [7:0]  led_w  [NI];
  logic [7:0]  addr_w [NI];
  logic [7:0]  d_w    [NI];
  logic [7:0]  fa_w   [NI];
  logic [7:0]  rq_w   [NI];

  logic [4:0] a0, a1, f0, f1;
  logic [5:0] a2, f2, a4, f4;
  logic [7:0] a3, f3;
  logic [0:0] d0, d1, d3, r0, r1, r3;
  logic [3:0] d2, r2;
  logic [1:0] d4, r4;

  logic [7:0] mem  [4][256];
  logic [7:0] mem4 [64];

  int nchk = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  function automatic int dep(input int i);
    case (i)
      0, 1:    return 32;
      3:       return 256;
      default: return 64;
    endcase
  endfunction

  function automatic int wid(input int i);
    case (i)
      2:       return 4;
      4:       return 2;
      default: return 1;
    endcase
  endfunction

  function automatic int seedv(input int i);
    return (i < 2) ? 1 : 'hA5;
  endfunction

  function automatic logic [255:0] dinit(input int i);
    case (i)
      0, 1:    return {224'd0, INIT_A};
      2:       return INIT_C;
      4:       return {128'd0, INIT_E};
      default: return '0;
    endcase
  endfunction

  function automatic int mask(input int i);
    return (1 << wid(i)) - 1;
  endfunction

  function automatic int init_word(input int i, input int a);
    logic [255:0] v;
    v = dinit(i) >> (a * wid(i));
    return int'(v[7:0]) & mask(i);
  endfunction

  function automatic logic [7:0] load_word(input int i, input int a);
    logic [255:0] v;
    v = (i == 1) ? {224'd0, LOAD_B} : dinit(i);
    v = v >> (a * wid(i));
    return v[7:0] & 8'(mask(i));
  endfunction

  function automatic int pat(input int i, input int a);
    return (seedv(i) ^ a) & mask(i);
  endfunction

  lutram_march_tester #(.DEPTH(32), .WIDTH(1), .INIT(INIT_A), .SEED(8'h01)) u0 (
    .clk_i(clk), .rst_i(rst[0]), .start_i(start[0]), .ram_we_o(we_w[0]), .ram_addr_o(a0),
    .ram_d_o(d0), .ram_q_i(r0), .busy_o(busy_w[0]), .done_o(done_w[0]), .pass_o(pass_w[0]),
    .err_cnt_o(err_w[0]), .fail_addr_o(f0), .fail_phase_o(fp_w[0]), .q_o(led_w[0]));

  lutram_march_tester #(.DEPTH(32), .WIDTH(1), .INIT(INIT_A), .SEED(8'h01)) u1 (
    .clk_i(clk), .rst_i(rst[1]), .start_i(start[1]), .ram_we_o(we_w[1]), .ram_addr_o(a1),
    .ram_d_o(d1), .ram_q_i(r1), .busy_o(busy_w[1]), .done_o(done_w[1]), .pass_o(pass_w[1]),
    .err_cnt_o(err_w[1]), .fail_addr_o(f1), .fail_phase_o(fp_w[1]), .q_o(led_w[1]));

  lutram_march_tester #(.DEPTH(64), .WIDTH(4), .INIT(INIT_C)) u2 (
    .clk_i(clk), .rst_i(rst[2]), .start_i(start[2]), .ram_we_o(we_w[2]), .ram_addr_o(a2),
    .ram_d_o(d2), .ram_q_i(r2), .busy_o(busy_w[2]), .done_o(done_w[2]), .pass_o(pass_w[2]),
    .err_cnt_o(err_w[2]), .fail_addr_o(f2), .fail_phase_o(fp_w[2]), .q_o(led_w[2]));

  lutram_march_tester #(.DEPTH(256), .WIDTH(1)) u3 (
    .clk_i(clk), .rst_i(rst[3]), .start_i(start[3]), .ram_we_o(we_w[3]), .ram_addr_o(a3),
    .ram_d_o(d3), .ram_q_i(r3), .busy_o(busy_w[3]), .done_o(done_w[3]), .pass_o(pass_w[3]),
    .err_cnt_o(err_w[3]), .fail_addr_o(f3), .fail_phase_o(fp_w[3]), .q_o(led_w[3]));

  lutram_march_tester #(.DEPTH(64), .WIDTH(2), .INIT(INIT_E)) u4 (
    .clk_i(clk), .rst_i(rst[4]), .start_i(start[4]), .ram_we_o(we_w[4]), .ram_addr_o(a4),
    .ram_d_o(d4), .ram_q_i(r4), .busy_o(busy_w[4]), .done_o(done_w[4]), .pass_o(pass_w[4]),
    .err_cnt_o(err_w[4]), .fail_addr_o(f4), .fail_phase_o(fp_w[4]), .q_o(led_w[4]));

  // RAM models: 0/1 healthy, 2 has bit 2 of word 37 stuck high, 3 is read-only,
  // 4 writes on the falling edge.
  always_comb begin
    r0 = mem[0][a0][0:0];
    r1 = mem[1][a1][0:0];
    r2 = mem[2][a2][3:0] | ((a2 == 6'd37) ? 4'h4 : 4'h0);
    r3 = mem[3][a3][0:0];
    r4 = mem4[a4][1:0];
    rq_w[0] = {7'd0, r0};  rq_w[1] = {7'd0, r1};  rq_w[2] = {4'd0, r2};
    rq_w[3] = {7'd0, r3};  rq_w[4] = {6'd0, r4};
    addr_w[0] = {3'd0, a0}; addr_w[1] = {3'd0, a1}; addr_w[2] = {2'd0, a2};
    addr_w[3] = a3;         addr_w[4] = {2'd0, a4};
    d_w[0] = {7'd0, d0};    d_w[1] = {7'd0, d1};    d_w[2] = {4'd0, d2};
    d_w[3] = {7'd0, d3};    d_w[4] = {6'd0, d4};
    fa_w[0] = {3'd0, f0};   fa_w[1] = {3'd0, f1};   fa_w[2] = {2'd0, f2};
    fa_w[3] = f3;           fa_w[4] = {2'd0, f4};
  end

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (load[i]) begin
        for (int a = 0; a < 256; a++) mem[i][a] <= load_word(i, a);
      end
    end
    if (!load[0] && we_w[0]) mem[0][a0] <= {7'd0, d0};
    if (!load[1] && we_w[1]) mem[1][a1] <= {7'd0, d1};
    if (!load[2] && we_w[2]) mem[2][a2] <= {4'd0, d2};
  end

  always @(negedge clk) begin
    if (load[4]) begin
      for (int a = 0; a < 64; a++) mem4[a] <= load_word(4, a);
    end else if (we_w[4]) begin
      mem4[a4] <= {6'd0, d4};
    end
  end

  task automatic chk(input string nm, input int i, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s inst%0d: got %0h, expected %0h at %0t", nm, i, got, exp, $time);
    end
  endtask

  // Model: run cycle k counts from the start edge; a read in cycle k shows in
  // the error count from cycle k+2.
  int mode [NI];
  int kc   [NI];
  int mcnt [NI];
  int mfa  [NI];
  int mfp  [NI];
  bit mpass[NI];
  bit cur  [NI];
  bit p1   [NI];
  bit p2   [NI];
  int cura [NI], curp [NI], p1a [NI], p1p [NI], p2a [NI], p2p [NI];

  task automatic model_step(input int i);
    int D, ea, ph, ev, ed, j;
    logic ewe, rd;
    logic [7:0] eq;
    D = dep(i);
    if (rst[i]) begin
      mode[i] = 0; mcnt[i] = 0; mfa[i] = 0; mfp[i] = 0; mpass[i] = 0;
      p1[i] = 0; p2[i] = 0; cur[i] = 0;
    end else if (mode[i] != 1 && start[i]) begin
      mode[i] = 1; kc[i] = 0; mcnt[i] = 0; mfa[i] = 0; mfp[i] = 0; mpass[i] = 0;
      p1[i] = 0; p2[i] = 0; cur[i] = 0;
    end else if (mode[i] == 1) begin
      p2[i] = p1[i];  p2a[i] = p1a[i];  p2p[i] = p1p[i];
      p1[i] = cur[i]; p1a[i] = cura[i]; p1p[i] = curp[i];
      cur[i] = 0;
      kc[i]++;
      if (p2[i]) begin
        if (mcnt[i] == 0) begin
          mfa[i] = p2a[i];
          mfp[i] = p2p[i];
        end
        if (mcnt[i] < 65535) mcnt[i]++;
      end
      if (kc[i] == 5 * D + 1) begin
        mode[i]  = 2;
        mpass[i] = (mcnt[i] == 0);
      end
    end

    if (mode[i] == 0) begin
      chk("idle_we", i, we_w[i], 0);      chk("idle_addr", i, addr_w[i], 0);
      chk("idle_d", i, d_w[i], 0);        chk("idle_busy", i, busy_w[i], 0);
      chk("idle_done", i, done_w[i], 0);  chk("idle_pass", i, pass_w[i], 0);
      chk("idle_err", i, err_w[i], 0);    chk("idle_faddr", i, fa_w[i], 0);
      chk("idle_fphase", i, fp_w[i], 0);  chk("idle_led", i, led_w[i], 0);
    end else if (mode[i] == 1 && kc[i] < 5 * D) begin
      ewe = 0; rd = 0; ev = 0; ed = 0;
      if (kc[i] < D) begin
        ph = 0; ea = kc[i]; rd = 1; ev = init_word(i, ea);
      end else if (kc[i] < 2 * D) begin
        ph = 1; ea = kc[i] - D; ewe = 1; ed = pat(i, ea);
      end else if (kc[i] < 4 * D) begin
        ph = 2; j = kc[i] - 2 * D; ea = j / 2;
        if (j % 2 == 0) begin
          rd = 1; ev = pat(i, ea);
        end else begin
          ewe = 1; ed = ~pat(i, ea) & mask(i);
        end
      end else begin
        ph = 3; ea = 5 * D - 1 - kc[i]; rd = 1; ev = ~pat(i, ea) & mask(i);
      end
      chk("we", i, we_w[i], ewe);
      chk("addr", i, addr_w[i], ea);
      if (ewe) chk("wdata", i, d_w[i], ed);
      chk("busy", i, busy_w[i], 1);       chk("done", i, done_w[i], 0);
      chk("pass", i, pass_w[i], 0);       chk("err_cnt", i, err_w[i], mcnt[i]);
      chk("fail_addr", i, fa_w[i], mfa[i]); chk("fail_phase", i, fp_w[i], mfp[i]);
      eq = {1'b0, 1'b0, 1'b1, mcnt[i] != 0, 1'b0, 2'(ph), 1'(ea)};
      chk("led", i, led_w[i], eq);
      cur[i]  = rd && (int'(rq_w[i]) != ev);
      cura[i] = ea;
      curp[i] = ph;
    end else if (mode[i] == 1) begin
      chk("fin_we", i, we_w[i], 0);       chk("fin_busy", i, busy_w[i], 1);
      chk("fin_done", i, done_w[i], 0);   chk("fin_err", i, err_w[i], mcnt[i]);
      eq = {1'b0, 1'b0, 1'b1, mcnt[i] != 0, 4'd0};
      chk("fin_led", i, led_w[i][7:1], eq[7:1]);
    end else begin
      chk("done_we", i, we_w[i], 0);      chk("done_busy", i, busy_w[i], 0);
      chk("done_done", i, done_w[i], 1);  chk("done_pass", i, pass_w[i], mpass[i]);
      chk("done_err", i, err_w[i], mcnt[i]);
      chk("done_faddr", i, fa_w[i], mfa[i]); chk("done_fphase", i, fp_w[i], mfp[i]);
      eq = {mpass[i], 1'b1, 1'b0, mcnt[i] != 0, 4'd0};
      chk("done_led", i, led_w[i], eq);
    end
  endtask

  always @(posedge clk) begin
    #1;
    for (int i = 0; i < NI; i++) model_step(i);
  end

  task automatic step();
    @(posedge clk);
    #3;
  endtask

  task automatic do_load(input int i);
    load[i] = 1'b1;
    step();
    load[i] = 1'b0;
  endtask

  task automatic run(input int i, output int ncyc, output int nwe);
    start[i] = 1'b1;
    step();
    start[i] = 1'b0;
    chk("start_busy", i, busy_w[i], 1);
    chk("start_done_clr", i, done_w[i], 0);
    chk("start_err_clr", i, err_w[i], 0);
    ncyc = 0;
    nwe  = 0;
    while (done_w[i] !== 1'b1 && ncyc <= 6 * dep(i) + 10) begin
      if (we_w[i]) nwe++;
      step();
      ncyc++;
    end
  endtask

  initial begin
    int nc, nw;
    for (int i = 0; i < NI; i++) begin
      rst[i] = 1'b1; start[i] = 1'b0; load[i] = 1'b0;
    end
    repeat (3) step();
    for (int i = 0; i < NI; i++) begin
      rst[i] = 1'b0; load[i] = 1'b1;
    end
    step();
    for (int i = 0; i < NI; i++) load[i] = 1'b0;
    step();

    run(0, nc, nw);
    chk("A_done_cycle", 0, nc, 161);    chk("A_we_cycles", 0, nw, 64);
    chk("A_pass", 0, pass_w[0], 1);     chk("A_err", 0, err_w[0], 0);

    run(1, nc, nw);
    chk("B_done_cycle", 1, nc, 161);    chk("B_err", 1, err_w[1], 1);
    chk("B_faddr", 1, fa_w[1], 0);      chk("B_fphase", 1, fp_w[1], 0);
    chk("B_pass", 1, pass_w[1], 0);

    run(2, nc, nw);
    chk("C_done_cycle", 2, nc, 321);    chk("C_we_cycles", 2, nw, 128);
    chk("C_err", 2, err_w[2], 1);       chk("C_faddr", 2, fa_w[2], 37);
    chk("C_fphase", 2, fp_w[2], 2);     chk("C_pass", 2, pass_w[2], 0);

    run(3, nc, nw);
    chk("D_done_cycle", 3, nc, 1281);   chk("D_busy", 3, busy_w[3], 0);
    chk("D_err", 3, err_w[3], 256);     chk("D_faddr", 3, fa_w[3], 0);
    chk("D_fphase", 3, fp_w[3], 2);     chk("D_pass", 3, pass_w[3], 0);

    start[4] = 1'b1;
    step();
    start[4] = 1'b0;
    repeat (100) step();
    rst[4] = 1'b1;
    step();
    rst[4] = 1'b0;
    chk("E_rst_busy", 4, busy_w[4], 0); chk("E_rst_we", 4, we_w[4], 0);
    chk("E_rst_addr", 4, addr_w[4], 0); chk("E_rst_led", 4, led_w[4], 0);
    do_load(4);
    run(4, nc, nw);
    chk("E1_done_cycle", 4, nc, 321);   chk("E1_we_cycles", 4, nw, 128);
    chk("E1_pass", 4, pass_w[4], 1);
    do_load(4);
    run(4, nc, nw);
    chk("E2_done_cycle", 4, nc, 321);   chk("E2_pass", 4, pass_w[4], 1);
    chk("E2_err", 4, err_w[4], 0);
    step();

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule

`default_nettype wire
